conv_feeder: RTL and testbench

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_feeder.sv | 123 ++++++++++++
 tb/tb_conv_feeder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_feeder.sv
// conv_feeder: buffers a filter and an image, streams them to a convolution engine, collects its results.
// Ports: clk/rst_n (async active-low); wr_en/wr_addr/wr_data load the buffer while idle
// (0..24 filter taps, 32..95 pixels); cfg_* plus start launch a job; busy/done/err_cfg/err_timeout
// report job status; filter_valid/image_valid/in_data and the size/mode outputs feed the engine;
// out_valid/out_data come back from it and are republished on res_valid/res_data/res_idx.
module conv_feeder (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [6:0]         wr_addr,
  input  logic signed [7:0]  wr_data,
  input  logic               cfg_filter_size,
  input  logic [3:0]         cfg_image_size,
  input  logic               cfg_pad_mode,
  input  logic               cfg_act_mode,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err_cfg,
  output logic               err_timeout,
  output logic               filter_valid,
  output logic               image_valid,
  output logic               filter_size,
  output logic [3:0]         image_size,
  output logic               pad_mode,
  output logic               act_mode,
  output logic signed [7:0]  in_data,
  input  logic               out_valid,
  input  logic signed [15:0] out_data,
  output logic               res_valid,
  output logic signed [15:0] res_data,
  output logic [5:0]         res_idx
);
  localparam logic [2:0] IDLE = 3'd0, FILT = 3'd1, GAP = 3'd2, IMG = 3'd3, WAIT = 3'd4;
  logic [2:0] state, ns;
  logic [6:0] k, nk, rcnt, nr, npix, flast;
  logic [8:0] idle, ni;
  logic c_fs, c_pad, c_act, n_fs, n_pad, n_act;
  logic [3:0] c_n, n_n;
  logic wr_ok, cfg_ok, go, acc, last_res, tmo;
  logic signed [7:0] fdat;
  logic signed [7:0] filt [0:31];
  logic signed [7:0] pix [0:63];
  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    wr_ok = wr_en && state == IDLE;
    cfg_ok = cfg_image_size >= 4'd4 && cfg_image_size <= 4'd8;
    go = start && state == IDLE && cfg_ok;
    n_fs = go ? cfg_filter_size : c_fs;
    n_pad = go ? cfg_pad_mode : c_pad;
    n_act = go ? cfg_act_mode : c_act;
    n_n = go ? cfg_image_size : c_n;
    npix = {3'd0, c_n} * {3'd0, c_n};
    flast = c_fs ? 7'd24 : 7'd8;
    acc = (state == IMG || state == WAIT) && out_valid;
    nr = go ? 7'd0 : rcnt + {6'd0, acc};
    last_res = state == WAIT && nr >= npix;
    ni = state == WAIT && !out_valid ? idle + 9'd1 : 9'd0;
    tmo = state == WAIT && !last_res && ni[8];
    ns = state == IDLE ? (go ? FILT : IDLE) :
         state == FILT ? (k == flast ? GAP : FILT) :
         state == GAP  ? IMG :
         state == IMG  ? (k == npix - 7'd1 ? WAIT : IMG) :
         state == WAIT ? (last_res || tmo ? IDLE : WAIT) : IDLE;
    nk = ns == state && (state == FILT || state == IMG) ? k + 7'd1 : 7'd0;
    // A tap written in the start cycle must already be visible on the first FILT cycle.
    fdat = wr_ok && wr_addr == {2'd0, nk[4:0]} ? wr_data : filt[nk[4:0]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      rcnt <= '0;
      idle <= '0;
      c_fs <= 1'b0;
      c_pad <= 1'b0;
      c_act <= 1'b0;
      c_n <= '0;
      for (int i = 0; i < 32; i++) filt[i] <= '0;
      for (int i = 0; i < 64; i++) pix[i] <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_cfg <= 1'b0;
      err_timeout <= 1'b0;
      filter_valid <= 1'b0;
      image_valid <= 1'b0;
      filter_size <= 1'b0;
      image_size <= '0;
      pad_mode <= 1'b0;
      act_mode <= 1'b0;
      in_data <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_idx <= '0;
    end else begin
      state <= ns;
      k <= nk;
      rcnt <= nr;
      idle <= ni;
      c_fs <= n_fs;
      c_pad <= n_pad;
      c_act <= n_act;
      c_n <= n_n;
      if (wr_ok && wr_addr < 7'd25) filt[wr_addr[4:0]] <= wr_data;
      // Pixel address 32..95 maps to index 0..63 by flipping bit 5.
      if (wr_ok && wr_addr >= 7'd32 && wr_addr < 7'd96) pix[{~wr_addr[5], wr_addr[4:0]}] <= wr_data;
      busy <= ns != IDLE;
      done <= last_res;
      err_cfg <= start && state == IDLE && !cfg_ok;
      err_timeout <= tmo;
      filter_valid <= ns == FILT;
      image_valid <= ns == IMG;
      in_data <= ns == FILT ? fdat : ns == IMG ? pix[nk[5:0]] : 8'sd0;
      filter_size <= ns == FILT && n_fs;
      pad_mode <= ns == FILT && n_pad;
      act_mode <= ns == FILT && n_act;
      image_size <= ns == FILT ? n_n : 4'd0;
      res_valid <= acc;
      res_data <= acc ? out_data : 16'sd0;
      res_idx <= acc ? rcnt[5:0] : 6'd0;
    end
  end
endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: directed and randomized jobs checked against a cycle-position model of the feeder.
module tb_conv_feeder;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0;
  logic [6:0] wr_addr = '0;
  logic signed [7:0] wr_data = '0;
  logic cfg_filter_size = 1'b0, cfg_pad_mode = 1'b0, cfg_act_mode = 1'b0;
  logic [3:0] cfg_image_size = '0;
  logic busy, done, err_cfg, err_timeout, filter_valid, image_valid;
  logic filter_size, pad_mode, act_mode, res_valid;
  logic [3:0] image_size;
  logic signed [7:0] in_data;
  logic out_valid = 1'b0;
  logic signed [15:0] out_data = '0;
  logic signed [15:0] res_data;
  logic [5:0] res_idx;
  int total = 0, bad = 0;
  logic signed [7:0] mfilt [25];
  logic signed [7:0] mpix [64];

  conv_feeder dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_filter_size(cfg_filter_size), .cfg_image_size(cfg_image_size),
    .cfg_pad_mode(cfg_pad_mode), .cfg_act_mode(cfg_act_mode), .start(start),
    .busy(busy), .done(done), .err_cfg(err_cfg), .err_timeout(err_timeout),
    .filter_valid(filter_valid), .image_valid(image_valid), .filter_size(filter_size),
    .image_size(image_size), .pad_mode(pad_mode), .act_mode(act_mode), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .res_valid(res_valid), .res_data(res_data),
    .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, err_cfg, err_timeout, filter_valid, image_valid, filter_size,
        pad_mode, act_mode, image_size, in_data}, 32'd0);
    chk({tag, "_res"}, {res_valid, res_data, res_idx}, 32'd0);
  endtask

  task automatic wr(input logic [6:0] a, input logic signed [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
    if (a < 25) mfilt[a] = d;
    else if (a >= 32 && a < 96) mpix[a - 32] = d;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 25; i++) mfilt[i] = '0;
    for (int i = 0; i < 64; i++) mpix[i] = '0;
  endtask

  // Cycle c counts from 1 = first cycle after the start edge: FILT 1..f, GAP f+1,
  // IMG f+2..f+1+N*N, WAIT from w = f+N*N+2.
  task automatic run_job(input bit fs, input int n, input bit pad, input bit act, input bit quiet,
                         input int abort_at, input bit poke, input bit sw,
                         input logic signed [7:0] swd);
    int f, np, w, got, c, e;
    bit fin, pacc, fv, iv, dn, to;
    logic signed [15:0] pd;
    f = fs ? 25 : 9;
    np = n * n;
    w = f + np + 2;
    got = 0;
    c = 1;
    fin = 0;
    pacc = 0;
    pd = '0;
    cfg_filter_size = fs;
    cfg_image_size = 4'(n);
    cfg_pad_mode = pad;
    cfg_act_mode = act;
    start = 1'b1;
    if (sw) begin
      wr_en = 1'b1;
      wr_addr = 7'd0;
      wr_data = swd;
      mfilt[0] = swd;
    end
    step();
    start = 1'b0;
    wr_en = 1'b0;
    while (!fin) begin
      if (c > 4000) begin
        chk("cycle_bound", c, 0);
        out_valid = 1'b0;
        return;
      end
      fv = c <= f;
      iv = c >= f + 2 && c < w;
      e = fv ? int'(mfilt[c - 1]) : iv ? int'(mpix[c - f - 2]) : 0;
      chk("filter_valid", filter_valid, fv);
      chk("image_valid", image_valid, iv);
      chk("in_data", in_data, e);
      chk("cfg_out", {filter_size, pad_mode, act_mode, image_size}, fv ? {fs, pad, act, 4'(n)} : 7'd0);
      chk("res_valid", res_valid, pacc);
      if (pacc) begin
        chk("res_data", res_data, pd);
        chk("res_idx", res_idx, got);
        got++;
      end
      dn = pacc && got == np;
      to = quiet && c == w + 256;
      chk("done", done, dn);
      chk("err_timeout", err_timeout, to);
      chk("err_cfg", err_cfg, 0);
      chk("busy", busy, !(dn || to));
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_image_valid", image_valid, 0);
        chk("abort_busy", busy, 0);
        out_valid = 1'b0;
        step();
        chk_zero("abort_hold");
        rst_n = 1'b1;
        clear_model();
        step();
        chk_zero("abort_after");
        return;
      end
      fin = dn || to;
      wr_en = 1'b0;
      start = 1'b0;
      if (poke && c == 3) begin
        wr_en = 1'b1;
        wr_addr = 7'd0;
        wr_data = 8'sh7F;
        start = 1'b1;
        cfg_filter_size = ~fs;
        cfg_image_size = 4'd9;
        cfg_pad_mode = ~pad;
      end
      out_data = 16'($urandom);
      pd = out_data;
      if (quiet || fin) out_valid = 1'b0;
      else if (c <= f + 1) out_valid = 1'($urandom % 2);
      else if (c < w) out_valid = got < np - 1 && $urandom % 3 == 0;
      else out_valid = got < np && $urandom % 2 == 0;
      pacc = out_valid && c >= f + 2;
      step();
      c++;
    end
    wr_en = 1'b0;
    start = 1'b0;
    chk("done_single", done, 0);
    chk("err_timeout_single", err_timeout, 0);
    chk("busy_after", busy, 0);
    chk("res_valid_after", res_valid, 0);
  endtask

  task automatic bad_cfg(input logic [3:0] n);
    cfg_image_size = n;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_cfg_pulse", err_cfg, 1);
    chk("err_cfg_busy", busy, 0);
    chk("err_cfg_valids", {filter_valid, image_valid}, 0);
    step();
    chk("err_cfg_clear", err_cfg, 0);
    chk("err_cfg_busy2", busy, 0);
    chk("err_cfg_valids2", {filter_valid, image_valid}, 0);
  endtask

  initial begin
    clear_model();
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    chk_zero("post_reset");
    for (int i = 0; i < 25; i++) wr(7'(i), 8'(i + 1));
    for (int i = 0; i < 64; i++) wr(7'(32 + i), 8'($urandom));
    wr(7'd25, 8'sh55);
    wr(7'd31, 8'sh22);
    wr(7'd96, 8'sh66);
    run_job(0, 4, 0, 0, 0, 0, 0, 0, 8'sd0);
    run_job(1, 8, 1, 1, 0, 0, 0, 0, 8'sd0);
    bad_cfg(4'd9);
    bad_cfg(4'd3);
    bad_cfg(4'd15);
    run_job(0, 4, 0, 0, 1, 0, 0, 0, 8'sd0);
    run_job(0, 4, 0, 0, 0, 15, 0, 0, 8'sd0);
    for (int i = 0; i < 25; i++) wr(7'(i), 8'($urandom));
    for (int i = 0; i < 64; i++) wr(7'(32 + i), 8'($urandom));
    run_job(1, 6, 0, 1, 0, 0, 0, 0, 8'sd0);
    run_job(0, 5, 1, 0, 0, 0, 1, 0, 8'sd0);
    run_job(0, 4, 0, 0, 0, 0, 0, 0, 8'sd0);
    run_job(1, 4, 0, 0, 0, 0, 0, 1, -8'sd7);
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 8; i++) wr(7'($urandom % 96), 8'($urandom));
      run_job(1'($urandom % 2), 4 + int'($urandom % 5), 1'($urandom % 2), 1'($urandom % 2),
              0, 0, 0, 0, 8'sd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
